// File: rtl/patt_pkg.sv
// ============================================================================
//  Module      : patt_pkg
//  Description : Shared constants for the 1011 pattern-detector slice.
//                Holds the serializer state encoding and the detector's
//                state constants so both blocks agree on a single source.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package patt_pkg;

  // Serializer (patt_ser) state encoding
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [ST_W-1:0] ST_PAR   = 2'd2;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_PAR   = ST_PAR
  } ser_state_e;

  // Detector (1011 sequence) state constants: number of pattern bits matched
  localparam int unsigned DET_ST_W = 3;
  localparam logic [DET_ST_W-1:0] DET_S0   = 3'd0; // nothing matched
  localparam logic [DET_ST_W-1:0] DET_S1   = 3'd1; // "1"
  localparam logic [DET_ST_W-1:0] DET_S10  = 3'd2; // "10"
  localparam logic [DET_ST_W-1:0] DET_S101 = 3'd3; // "101"
  localparam logic [DET_ST_W-1:0] DET_HIT  = 3'd4; // "1011" seen

endpackage : patt_pkg

`default_nettype wire

// File: rtl/patt_ser.sv
// ============================================================================
//  Module      : patt_ser
//  Description : Parallel-in / serial-out feeder for the 1011 detector.
//                Accepts W-bit words over valid/ready and shifts them out
//                MSB-first, one bit per clock, streaming back-to-back words
//                without an idle gap.
//  Config      : define PATT_SER_PAR_EN to append one even-parity bit
//                (XOR of the W data bits) after every word.
//  Ports       : clk    - clock, rising edge
//                rst    - asynchronous active-high reset
//                d      - parallel word, sampled on the handshake edge
//                d_vld  - upstream word valid
//                d_rdy  - block can take a word this cycle
//                o      - serial bit to detector input
//                o_vld  - o carries a data/parity bit
//                busy   - word in flight (same as o_vld)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module patt_ser
  import patt_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic         d_vld,
  output logic         d_rdy,
  output logic         o,
  output logic         o_vld,
  output logic         busy
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] c_last = CW'(W - 1);

  ser_state_e    r_state;
  ser_state_e    w_nxt;
  logic [W-1:0]  r_sreg;
  logic [CW-1:0] r_cnt;
  logic          w_rdy;
  logic          w_acc;
  logic          w_last;

`ifdef PATT_SER_PAR_EN
  // Running parity only matters when it is transmitted.
  logic          r_par;
`endif

  assign w_last = (r_cnt == c_last);
  // Ready is masked by reset so nothing can be accepted while it is held.
  assign d_rdy  = w_rdy & ~rst;
  assign w_acc  = d_vld & d_rdy;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // ------------------------------------------------- next state / handshake
  always_comb begin
    w_nxt = r_state;
    w_rdy = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rdy = 1'b1;
        if (d_vld) w_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last) begin
`ifdef PATT_SER_PAR_EN
          w_nxt = S_PAR;
`else
          // Last data bit doubles as the reload slot for gapless streaming.
          w_rdy = 1'b1;
          w_nxt = d_vld ? S_SHIFT : S_IDLE;
`endif
        end
      end
`ifdef PATT_SER_PAR_EN
      S_PAR: begin
        w_rdy = 1'b1;
        w_nxt = d_vld ? S_SHIFT : S_IDLE;
      end
`endif
      default: w_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
`ifdef PATT_SER_PAR_EN
      r_par  <= 1'b0;
`endif
    end else if (w_acc) begin
      r_sreg <= d;
      r_cnt  <= '0;
`ifdef PATT_SER_PAR_EN
      r_par  <= 1'b0;
`endif
    end else if (r_state == S_SHIFT) begin
      r_sreg <= r_sreg << 1;
`ifdef PATT_SER_PAR_EN
      r_par  <= r_par ^ r_sreg[W-1];
`endif
      // Exit from SHIFT happens at c_last, so the count never wraps in use.
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------- outputs
  // Output is a select between flop outputs only; no data-path logic in front.
  always_comb begin
    o     = 1'b0;
    o_vld = 1'b0;
    case (r_state)
      S_SHIFT: begin
        o     = r_sreg[W-1];
        o_vld = 1'b1;
      end
`ifdef PATT_SER_PAR_EN
      S_PAR: begin
        o     = r_par;
        o_vld = 1'b1;
      end
`endif
      default: begin
        o     = 1'b0;
        o_vld = 1'b0;
      end
    endcase
  end

  assign busy = o_vld;

endmodule : patt_ser

`default_nettype wire

// File: tb/tb_patt_ser.sv
// ============================================================================
//  Module      : tb_patt_ser
//  Description : Self-checking bench for patt_ser (W=8). Expected serial bits
//                are queued when a word is issued; a negedge monitor pops and
//                compares whenever o_vld is high.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_patt_ser;

  localparam int unsigned W = 8;
`ifdef PATT_SER_PAR_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FL = W + PB;   // serial frame length

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] d = '0;
  logic         d_vld = 1'b0;
  logic         d_rdy;
  logic         o;
  logic         o_vld;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  bit exp_q[$];
  int vld_total = 0;   // o_vld-high cycles seen by the monitor
  int run_len   = 0;   // current consecutive o_vld run
  int last_run  = 0;   // length of the most recently completed run

  patt_ser #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .d_vld (d_vld),
    .d_rdy (d_rdy),
    .o     (o),
    .o_vld (o_vld),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every valid serial bit.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy==o_vld", 32'(busy), 32'(o_vld));
      if (o_vld) begin
        vld_total++;
        run_len++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_bit: got o=%0b with empty queue at %0t", o, $time);
        end else begin
          check("serial_bit", 32'(o), 32'(exp_q.pop_front()));
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  function automatic bit parity(input logic [W-1:0] w);
    return ^w;
  endfunction

  // Issue a word: queue its expected bits, then hold d_vld until the
  // handshake edge. 'waited' counts negedges where d_rdy was still low.
  task automatic send(input logic [W-1:0] w, output int waited);
    int n;
    n = 0;
    d     = w;
    d_vld = 1'b1;
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
    if (PB != 0) exp_q.push_back(parity(w));
    while (!d_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!d_rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: d_rdy=%0b expected 1", d_rdy);
    end
    @(posedge clk);
    @(negedge clk);
    waited = n;
  endtask

  task automatic idle_until_drained();
    int n;
    n = 0;
    d_vld = 1'b0;
    while ((o_vld || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int wt;
    int base;

    // Reset state
    #3;
    check("rst_o",     32'(o),     32'd0);
    check("rst_o_vld", 32'(o_vld), 32'd0);
    check("rst_d_rdy", 32'(d_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_d_rdy", 32'(d_rdy), 32'd1);

    // No traffic for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_o",     32'(o),     32'd0);
      check("idle_o_vld", 32'(o_vld), 32'd0);
      check("idle_d_rdy", 32'(d_rdy), 32'd1);
    end

    // Single word 8'hB0: stream 10110000, o_vld high exactly one frame
    base = vld_total;
    send(8'hB0, wt);
    idle_until_drained();
    check("b0_vld_cycles", 32'(vld_total - base), 32'(FL));
    check("b0_run_len",    32'(last_run),         32'(FL));

    // Back-to-back A5 then 3C: gapless, ready only in the reload cycle
    send(8'hA5, wt);
    check("a5_accept_from_idle", 32'(wt), 32'd0);
    send(8'h3C, wt);
    // Counted from the first negedge after accept: cycles 1..FL-1 low.
    check("b2b_rdy_wait", 32'(wt), 32'(FL - 1));
    idle_until_drained();
    check("b2b_run_len", 32'(last_run), 32'(2 * FL));

    // Late d_vld: 8'h55 in flight, 8'hFF offered three cycles into it
    send(8'h55, wt);
    repeat (2) @(negedge clk);
    check("mid_word_rdy_low", 32'(d_rdy), 32'd0);
    send(8'hFF, wt);
    check("late_rdy_wait", 32'(wt), 32'(FL - 3));
    idle_until_drained();
    check("late_run_len", 32'(last_run), 32'(2 * FL));

    // Async reset after 3 bits of 8'hF0
    send(8'hF0, wt);
    d_vld = 1'b0;
    repeat (2) @(negedge clk);         // bits 1..3 checked by the monitor
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_o",     32'(o),     32'd0);
    check("arst_o_vld", 32'(o_vld), 32'd0);
    check("arst_d_rdy", 32'(d_rdy), 32'd0);
    check("arst_bits_left", 32'(exp_q.size()), 32'(FL - 3));
    exp_q.delete();                    // partial word is discarded
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_release_rdy",   32'(d_rdy), 32'd1);
    check("arst_release_o_vld", 32'(o_vld), 32'd0);
    send(8'hB0, wt);
    check("arst_next_from_idle", 32'(wt), 32'd0);
    idle_until_drained();

    // Parity framing words (7 -> parity 1, 3 -> parity 0 when enabled)
    send(8'h07, wt);
    send(8'h03, wt);
    check("par_rdy_wait", 32'(wt), 32'(FL - 1));
    idle_until_drained();
    check("par_run_len", 32'(last_run), 32'(2 * FL));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_patt_ser

`default_nettype wire
